// File: rtl/vga_timing_gen.sv
// Raster timing generator: undelayed x/y counters plus sync and display flags delayed by SYNC_DELAY stages.
// Optional feature: define VGA_FRAME_COUNT_EN to add an 8-bit frame_count output.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int SYNC_DELAY = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode bounds are 11 bits so an end value of exactly 1024 does not wrap to zero
    localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [2:0] IDLE_FLAGS = {~SYNC_POL, ~SYNC_POL, 1'b0};

    logic       h_raw;
    logic       v_raw;
    logic       de_raw;
    logic [2:0] raw_flags;
    logic [2:0] out_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (x == H_LAST) begin
            x <= '0;
            y <= (y == V_LAST) ? '0 : y + 10'd1;
        end else begin
            x <= x + 10'd1;
        end
    end

    assign h_raw  = ({1'b0, x} >= H_SYNC_START) && ({1'b0, x} < H_SYNC_END);
    assign v_raw  = ({1'b0, y} >= V_SYNC_START) && ({1'b0, y} < V_SYNC_END);
    assign de_raw = ({1'b0, x} < H_ACT_END) && ({1'b0, y} < V_ACT_END);

    assign raw_flags = {SYNC_POL ? h_raw : ~h_raw,
                        SYNC_POL ? v_raw : ~v_raw,
                        de_raw};

    assign line_start  = (x == 10'd0);
    assign frame_start = (x == 10'd0) && (y == 10'd0);

    // Flags are delayed so they align with registered overlay outputs downstream
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign out_flags = raw_flags;
        end else begin : g_delay
            logic [2:0] stage [SYNC_DELAY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        stage[i] <= IDLE_FLAGS;
                    end
                end else begin
                    stage[0] <= raw_flags;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign out_flags = stage[SYNC_DELAY-1];
        end
    endgenerate

    assign hsync      = out_flags[2];
    assign vsync      = out_flags[1];
    assign display_on = out_flags[0];

`ifdef VGA_FRAME_COUNT_EN
    // Advances on the edge that wraps the raster back to 0,0
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if ((x == H_LAST) && (y == V_LAST)) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: fixed vectors, corner sequences and random resets checked against a cycle-count model.
// Three instances: default timing (delay 1), a small active-high geometry (delay 2) and the same small geometry with delay 0.
module tb_vga_timing_gen;

    localparam int SH_A = 10, SH_FP = 3, SH_S = 4, SH_BP = 3;
    localparam int SV_A = 6,  SV_FP = 2, SV_S = 2, SV_BP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [9:0] m_x, m_y, s_x, s_y, z_x, z_y;
    logic m_ls, m_fs, m_hs, m_vs, m_de;
    logic s_ls, s_fs, s_hs, s_vs, s_de;
    logic z_ls, z_fs, z_hs, z_vs, z_de;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] m_fc, s_fc, z_fc;
`endif

    vga_timing_gen u_main (
        .clk(clk), .rst(rst), .x(m_x), .y(m_y), .line_start(m_ls), .frame_start(m_fs),
        .hsync(m_hs), .vsync(m_vs), .display_on(m_de)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(m_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP),
        .SYNC_POL(1'b1), .SYNC_DELAY(2)
    ) u_small (
        .clk(clk), .rst(rst), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs),
        .hsync(s_hs), .vsync(s_vs), .display_on(s_de)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(s_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP),
        .SYNC_POL(1'b0), .SYNC_DELAY(0)
    ) u_zero (
        .clk(clk), .rst(rst), .x(z_x), .y(z_y), .line_start(z_ls), .frame_start(z_fs),
        .hsync(z_hs), .vsync(z_vs), .display_on(z_de)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(z_fc)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles elapsed since the last reset edge; every output is derived from it
    int t = 0;
    bit run = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            t   <= 0;
            run <= 1'b1;
        end else begin
            t <= t + 1;
        end
    end

    typedef struct {
        int x, y, fc;
        bit ls, fs, hs, vs, de;
    } exp_t;

    function automatic exp_t model(int tc, int ha, int hfp, int hs, int hbp,
                                   int va, int vfp, int vs, int vbp, bit pol, int d);
        exp_t e;
        int ht = ha + hfp + hs + hbp;
        int vt = va + vfp + vs + vbp;
        int p, px, py;
        e.x  = tc % ht;
        e.y  = (tc / ht) % vt;
        e.ls = (e.x == 0);
        e.fs = (e.x == 0) && (e.y == 0);
        e.fc = (tc / (ht * vt)) % 256;
        if (tc < d) begin
            e.hs = ~pol;
            e.vs = ~pol;
            e.de = 1'b0;
        end else begin
            p  = tc - d;
            px = p % ht;
            py = (p / ht) % vt;
            e.hs = ((px >= ha + hfp) && (px < ha + hfp + hs)) ? pol : ~pol;
            e.vs = ((py >= va + vfp) && (py < va + vfp + vs)) ? pol : ~pol;
            e.de = (px < ha) && (py < va);
        end
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0d)", name, actual, expected, t);
        end
    endtask

    task automatic apply_stimulus(input int reset_cycles);
        rst = 1'b1;
        repeat (reset_cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycle-by-cycle scoreboard on all three instances
    always @(negedge clk) begin
        if (run) begin
            exp_t em, es, ez;
            em = model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1);
            es = model(t, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP, 1'b1, 2);
            ez = model(t, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP, 1'b0, 0);
            check_output("main.x", 32'(m_x), 32'(em.x));
            check_output("main.y", 32'(m_y), 32'(em.y));
            check_output("main.line_start", 32'(m_ls), 32'(em.ls));
            check_output("main.frame_start", 32'(m_fs), 32'(em.fs));
            check_output("main.hsync", 32'(m_hs), 32'(em.hs));
            check_output("main.vsync", 32'(m_vs), 32'(em.vs));
            check_output("main.display_on", 32'(m_de), 32'(em.de));
            check_output("small.x", 32'(s_x), 32'(es.x));
            check_output("small.y", 32'(s_y), 32'(es.y));
            check_output("small.line_start", 32'(s_ls), 32'(es.ls));
            check_output("small.frame_start", 32'(s_fs), 32'(es.fs));
            check_output("small.hsync", 32'(s_hs), 32'(es.hs));
            check_output("small.vsync", 32'(s_vs), 32'(es.vs));
            check_output("small.display_on", 32'(s_de), 32'(es.de));
            check_output("zero.x", 32'(z_x), 32'(ez.x));
            check_output("zero.y", 32'(z_y), 32'(ez.y));
            check_output("zero.hsync", 32'(z_hs), 32'(ez.hs));
            check_output("zero.vsync", 32'(z_vs), 32'(ez.vs));
            check_output("zero.display_on", 32'(z_de), 32'(ez.de));
`ifdef VGA_FRAME_COUNT_EN
            check_output("main.frame_count", 32'(m_fc), 32'(em.fc));
            check_output("small.frame_count", 32'(s_fc), 32'(es.fc));
            check_output("zero.frame_count", 32'(z_fc), 32'(ez.fc));
`endif
        end
    end

    typedef struct {
        int t, x, y;
        bit hs, vs, de, ls, fs;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int guard, low, first_x, last_x, wraps;
        int c_vs, c_de, c_fs, c_zde, c_zvs;
        logic [9:0] prev_y;

        vecs[0]  = '{0,   0,   0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{640, 640, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{641, 641, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{656, 656, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{657, 657, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{752, 752, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{753, 753, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{799, 799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{800, 0,   1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{801, 1,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        apply_stimulus(3);

        for (int i = 0; i < 11; i++) begin
            guard = 0;
            while (t < vecs[i].t && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            check_output("vec.x", 32'(m_x), 32'(vecs[i].x));
            check_output("vec.y", 32'(m_y), 32'(vecs[i].y));
            check_output("vec.hsync", 32'(m_hs), 32'(vecs[i].hs));
            check_output("vec.vsync", 32'(m_vs), 32'(vecs[i].vs));
            check_output("vec.display_on", 32'(m_de), 32'(vecs[i].de));
            check_output("vec.line_start", 32'(m_ls), 32'(vecs[i].ls));
            check_output("vec.frame_start", 32'(m_fs), 32'(vecs[i].fs));
        end

        // One full line of hsync, starting at x==0
        guard = 0;
        while (m_x != 10'd0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check_output("hsync.align_timeout", 32'(guard < 1000), 32'd1);
        low = 0; first_x = -1; last_x = -1;
        for (int i = 0; i < 800; i++) begin
            if (m_hs == 1'b0) begin
                if (first_x < 0) first_x = int'(m_x);
                last_x = int'(m_x);
                low++;
            end
            @(negedge clk);
        end
        check_output("hsync.low_cycles", 32'(low), 32'd96);
        check_output("hsync.first_low_x", 32'(first_x), 32'd657);
        check_output("hsync.last_low_x", 32'(last_x), 32'd752);

        // One full frame window on the small geometries
        c_vs = 0; c_de = 0; c_fs = 0; c_zde = 0; c_zvs = 0; wraps = 0;
        prev_y = s_y;
        for (int i = 0; i < 240; i++) begin
            @(negedge clk);
            if (s_vs) c_vs++;
            if (s_de) c_de++;
            if (s_fs) c_fs++;
            if (z_de) c_zde++;
            if (!z_vs) c_zvs++;
            if (prev_y == 10'd11 && s_y == 10'd0) wraps++;
            prev_y = s_y;
        end
        check_output("frame.vsync_cycles", 32'(c_vs), 32'd40);
        check_output("frame.display_cycles", 32'(c_de), 32'd60);
        check_output("frame.frame_starts", 32'(c_fs), 32'd1);
        check_output("frame.y_wraps", 32'(wraps), 32'd1);
        check_output("frame.zero_display_cycles", 32'(c_zde), 32'd60);
        check_output("frame.zero_vsync_cycles", 32'(c_zvs), 32'd40);

        // Zero-delay flags switch in the same cycle as x
        guard = 0;
        while (z_x != 10'd12 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_output("zero.hsync_x12", 32'(z_hs), 32'd1);
        @(negedge clk);
        check_output("zero.hsync_x13", 32'(z_hs), 32'd0);
        repeat (3) @(negedge clk);
        check_output("zero.hsync_x16", 32'(z_hs), 32'd0);
        @(negedge clk);
        check_output("zero.hsync_x17", 32'(z_hs), 32'd1);

        // Mid-frame reset on the default geometry at x=700, y=3
        guard = 0;
        while (!(m_x == 10'd700 && m_y == 10'd3) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check_output("midreset.reach", 32'(guard < 5000), 32'd1);
        check_output("midreset.hsync_before", 32'(m_hs), 32'd0);
        apply_stimulus(1);
        check_output("midreset.x", 32'(m_x), 32'd0);
        check_output("midreset.y", 32'(m_y), 32'd0);
        check_output("midreset.hsync", 32'(m_hs), 32'd1);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            check_output("midreset.x_follow", 32'(m_x), 32'(i));
        end

`ifdef VGA_FRAME_COUNT_EN
        apply_stimulus(2);
        low = 0;
        for (int i = 0; i < 3 * 240 + 10 && low < 3; i++) begin
            @(negedge clk);
            if (z_fs) begin
                low++;
                check_output("frame_count.at_start", 32'(z_fc), 32'(low));
            end
        end
        check_output("frame_count.frames_seen", 32'(low), 32'd3);
        apply_stimulus(1);
        check_output("frame_count.reset", 32'(z_fc), 32'd0);
`endif

        // Random run lengths interrupted by random resets
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(900, 1)) @(negedge clk);
            apply_stimulus(int'($urandom_range(3, 1)));
        end
        repeat (50) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
